// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: per-digit anode scanning with frame snapshots.
// Optional leading-zero blanking when SEG_LZB_EN is defined.
module seg_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  hex_mode,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]       pcnt;
    logic [IW-1:0]       idx;
    logic                tick;
    logic                wrap;

    logic [4*DIGITS-1:0] snap_value;
    logic [DIGITS-1:0]   snap_dp;
    logic [DIGITS-1:0]   snap_blank;
    logic                snap_hex;

    logic [3:0]          nib;
    logic                cur_dp;
    logic                cur_dark;
    logic [DIGITS-1:0]   onehot;
    logic [DIGITS-1:0]   lzb;
    logic [6:0]          dec;

    assign tick       = (pcnt == PW'(REFRESH_DIV - 1));
    assign wrap       = tick && (idx == IW'(DIGITS - 1));
    assign frame_done = wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            idx  <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (wrap)
                idx <= '0;
            else if (tick)
                idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_value <= '0;
            snap_dp    <= '0;
            snap_blank <= '0;
            snap_hex   <= 1'b0;
        end else if (wrap) begin
            snap_value <= value;
            snap_dp    <= dp;
            snap_blank <= blank;
            snap_hex   <= hex_mode;
        end
    end

`ifdef SEG_LZB_EN
    // Walk down from the most significant digit; the run ends at the first non-blankable digit.
    always_comb begin
        logic lead;
        lzb  = '0;
        lead = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            lzb[i] = lead && (snap_value[4*i +: 4] == 4'h0) && !snap_dp[i];
            lead   = lzb[i];
        end
    end
`else
    assign lzb = '0;
`endif

    always_comb begin
        nib      = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        onehot   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = snap_value[4*i +: 4];
                cur_dp    = snap_dp[i];
                cur_dark  = snap_blank[i] | lzb[i];
                onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        dec = 7'b0111111;
        case (nib)
            4'h0: dec = 7'b1000000;
            4'h1: dec = 7'b1111001;
            4'h2: dec = 7'b0100100;
            4'h3: dec = 7'b0110000;
            4'h4: dec = 7'b0011001;
            4'h5: dec = 7'b0010010;
            4'h6: dec = 7'b0000010;
            4'h7: dec = 7'b1111000;
            4'h8: dec = 7'b0000000;
            4'h9: dec = 7'b0010000;
            4'hA: if (snap_hex) dec = 7'b0001000;
            4'hB: if (snap_hex) dec = 7'b0000011;
            4'hC: if (snap_hex) dec = 7'b1000110;
            4'hD: if (snap_hex) dec = 7'b0100001;
            4'hE: if (snap_hex) dec = 7'b0000110;
            4'hF: if (snap_hex) dec = 7'b0001110;
            default: dec = 7'b0111111;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg  <= '1;
            an   <= '1;
            dp_n <= 1'b1;
        end else if (cur_dark) begin
            seg  <= '1;
            an   <= '1;
            dp_n <= 1'b1;
        end else begin
            seg  <= dec;
            an   <= ~onehot;
            dp_n <= ~cur_dp;
        end
    end

endmodule
